// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - four-song ROM melody sequencer driving a tone generator note code
//
// Purpose: plays one of four ROM songs as a timed sequence of note codes.
//   Each ROM entry is {note, len}. An entry sounds for len*U - GAP_CYCLES cycles
//   and is followed by a GAP_CYCLES rest. A len of 0 marks the end of the song.
//
// Ports:
//   CLK_1M   in   1  system clock, rising edge
//   RESET    in   1  asynchronous active-low reset
//   START    in   1  level; starts playback from idle
//   STOP     in   1  level; aborts playback, wins over START
//   SONG_SEL in   2  song number, latched on an accepted START
//   TEMPO    in   2  unit-length select, latched on an accepted START
//   NOTE     out  4  note code, 0-14 pitch, 15 rest
//   PLAYING  out  1  high whenever not idle
//   DONE     out  1  one-cycle pulse on normal song completion
//   POS      out  5  index of the current ROM entry
module melody_sequencer #(
  parameter int unsigned U0         = 125000,
  parameter int unsigned U1         = 100000,
  parameter int unsigned U2         = 75000,
  parameter int unsigned U3         = 62500,
  parameter int unsigned GAP_CYCLES = 10000
) (
  input  logic       CLK_1M,
  input  logic       RESET,
  input  logic       START,
  input  logic       STOP,
  input  logic [1:0] SONG_SEL,
  input  logic [1:0] TEMPO,
  output logic [3:0] NOTE,
  output logic       PLAYING,
  output logic       DONE,
  output logic [4:0] POS
);

  localparam int CNT_W = 20;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       song_q, song_d;
  logic [1:0]       tempo_q, tempo_d;
  logic [4:0]       pos_q, pos_d;
  logic [3:0]       note_q, note_d;
  logic             playing_q, playing_d;
  logic             done_q, done_d;

  logic [6:0]       rom_data;
  logic [3:0]       entry_note;
  logic [2:0]       entry_len;
  logic [CNT_W-1:0] unit;
  logic [CNT_W-1:0] play_cycles;

  // Song ROM, entry = {note, len}. Song 3 deliberately has no end marker:
  // it runs through all 32 entries and ends on the last gap.
  function automatic logic [6:0] rom_entry(input logic [1:0] song, input logic [4:0] pos);
    logic [6:0] e;
    e = 7'd0;
    case (song)
      2'd0: begin
        case (pos)
          5'd0:    e = {4'd0,  3'd2};
          5'd1:    e = {4'd2,  3'd2};
          5'd2:    e = {4'd4,  3'd4};
          5'd3:    e = {4'd15, 3'd1};
          default: e = 7'd0;
        endcase
      end
      2'd1: begin
        case (pos)
          5'd0:    e = {4'd7,  3'd3};
          5'd1:    e = {4'd9,  3'd1};
          5'd2:    e = {4'd11, 3'd2};
          5'd3:    e = {4'd15, 3'd2};
          5'd4:    e = {4'd12, 3'd1};
          default: e = 7'd0;
        endcase
      end
      2'd2: begin
        case (pos)
          5'd0:    e = {4'd14, 3'd1};
          5'd1:    e = {4'd13, 3'd1};
          5'd2:    e = {4'd12, 3'd1};
          5'd3:    e = {4'd11, 3'd1};
          5'd4:    e = {4'd10, 3'd3};
          default: e = 7'd0;
        endcase
      end
      default: e = {pos[3:0], 3'd1};
    endcase
    return e;
  endfunction

  assign rom_data   = rom_entry(song_q, pos_q);
  assign entry_note = rom_data[6:3];
  assign entry_len  = rom_data[2:0];

  always_comb begin
    unit = CNT_W'(U0);
    case (tempo_q)
      2'd0: unit = CNT_W'(U0);
      2'd1: unit = CNT_W'(U1);
      2'd2: unit = CNT_W'(U2);
      2'd3: unit = CNT_W'(U3);
      default: unit = CNT_W'(U0);
    endcase
  end

  // Sounding portion of the entry; the rest of len*U belongs to the gap.
  assign play_cycles = CNT_W'(entry_len) * unit - CNT_W'(GAP_CYCLES);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    song_d  = song_q;
    tempo_d = tempo_q;
    pos_d   = pos_q;
    note_d  = 4'd15;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (START && !STOP) begin
          state_d = S_LOAD;
          song_d  = SONG_SEL;
          tempo_d = TEMPO;
          pos_d   = 5'd0;
        end
      end
      S_LOAD: begin
        if (entry_len == 3'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_PLAY;
          note_d  = entry_note;
          cnt_d   = play_cycles - CNT_W'(1);
        end
      end
      S_PLAY: begin
        // Counter holds cycles remaining after this one.
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(GAP_CYCLES) - CNT_W'(1);
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          note_d = entry_note;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (pos_q == 5'd31) begin
            // Last ROM slot finished: end of song, POS stays at 31.
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
            pos_d   = pos_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase

    // Abort overrides every other transition out of a playing state.
    if (state_q != S_IDLE && STOP) begin
      state_d = S_IDLE;
      pos_d   = 5'd0;
      cnt_d   = '0;
      note_d  = 4'd15;
      done_d  = 1'b0;
    end

    playing_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK_1M or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      song_q    <= 2'd0;
      tempo_q   <= 2'd0;
      pos_q     <= 5'd0;
      note_q    <= 4'd15;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      song_q    <= song_d;
      tempo_q   <= tempo_d;
      pos_q     <= pos_d;
      note_q    <= note_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign NOTE    = note_q;
  assign PLAYING = playing_q;
  assign DONE    = done_q;
  assign POS     = pos_q;

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL provide port CLK_1M  input  1  1 MHz system clock; all state changes on its rising edge.
REQ-002 SHALL provide port RESET  input  1  asynchronous, active-low reset; one clock, and RESET is asynchronous and active-low.
REQ-003 SHALL provide port START  input  1  level, sampled each cycle; starts playback from IDLE.
REQ-004 SHALL provide port STOP  input  1  level, sampled each cycle; aborts playback.
REQ-005 SHALL provide port SONG_SEL  input  2  song number 0-3; latched only on an accepted START.
REQ-006 SHALL provide port TEMPO  input  2  unit-length select; latched only on an accepted START.
REQ-007 SHALL provide port NOTE  output  4  note code to the tone generator: 0-14 pitch, 15 rest.
REQ-008 SHALL provide port PLAYING  output  1  high in every state except IDLE.
REQ-009 SHALL provide port DONE  output  1  one-cycle pulse on normal song completion.
REQ-010 SHALL provide port POS  output  5  index of the current ROM entry.

Function
REQ-011 SHALL contain an internal ROM of 4 songs x 32 entries; entry = {NOTE[3:0], LEN[2:0]}; LEN 0 = end marker; address = {SONG_SEL latch, POS}.
REQ-012 SHALL fix song 0 as: entry0 (0,2), entry1 (2,2), entry2 (4,4), entry3 (15,1), entry4 end; contents of songs 1-3 come from the team melody table.
REQ-013 SHALL derive unit length U from latched TEMPO: 0->125000, 1->100000, 2->75000, 3->62500 cycles.
REQ-014 SHALL implement the states IDLE, LOAD, PLAY, GAP, using a single cycle counter of at least 20 bits.
REQ-015 IDLE: NOTE=15, PLAYING=0; when START=1 and STOP=0, the block SHALL latch SONG_SEL and TEMPO, set POS=0, and go to LOAD.
REQ-016 LOAD (exactly 1 cycle, NOTE=15): the block SHALL read entry POS; if LEN=0, go to IDLE and pulse DONE on the same edge; else go to PLAY.
REQ-017 PLAY: NOTE SHALL equal the entry note for exactly LEN*U-10000 cycles, then the block goes to GAP.
REQ-018 GAP: NOTE SHALL be 15 for exactly 10000 cycles (articulation gap); then POS increments and the block goes to LOAD.
REQ-019 Each non-end entry SHALL therefore occupy exactly LEN*U+1 cycles from LOAD entry to the next LOAD entry.
REQ-020 The block SHALL treat POS=31 completing GAP as the end of the song: go to IDLE with a DONE pulse, with no wrap to 0.
REQ-021 When STOP=1 in any non-IDLE state, the next edge SHALL go to IDLE with NOTE=15, PLAYING=0, POS=0, and no DONE pulse.
REQ-022 On simultaneous START and STOP, STOP SHALL win; START SHALL be ignored outside IDLE.
REQ-023 SONG_SEL and TEMPO changes during playback SHALL have no effect until the next accepted START.
REQ-024 DONE SHALL never be high for more than 1 cycle; START held high after DONE SHALL restart the song on the following cycle.
REQ-025 NOTE, PLAYING, DONE and POS SHALL be registered outputs.

Reset
REQ-026 RESET=0 SHALL immediately force IDLE, NOTE=15, PLAYING=0, DONE=0, POS=0, counter=0, latched SONG_SEL=0 and latched TEMPO=0.
REQ-027 Reset asserted mid-note SHALL abort without a DONE pulse; after release the block SHALL wait in IDLE for START.

Verification
REQ-028 START pulse, SONG_SEL=0, TEMPO=3 -> NOTE=15 for 1 cycle, then 0 for 115000 cycles, then 15 for 10000 cycles, then 1 LOAD cycle, then 2 for 115000 cycles.
REQ-029 Full song 0 at TEMPO=3 -> DONE pulses once, 562505 cycles after the LOAD entry, with POS=4 at DONE and PLAYING falling with it.
REQ-030 STOP asserted 50000 cycles into entry1 -> next cycle NOTE=15, PLAYING=0, POS=0, and no DONE pulse.
REQ-031 START and STOP high together in IDLE -> the block stays in IDLE; changing TEMPO from 3 to 0 mid-song -> entry lengths stay on the 62500 base.
REQ-032 RESET low for 3 cycles during PLAY -> outputs at reset values immediately, with no DONE; a START after release replays from POS=0.
REQ-033 A song ROM with no end marker -> DONE after entry 31's GAP, and POS does not wrap to 0 before IDLE.
